// File: rtl/cook_pkg.sv
// Shared constants for the cook timer: state encoding, time-field width and LED bit positions.
package cook_pkg;

    localparam int FIELD_W = 6;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int LED_COOK = 0;
    localparam int LED_DONE = 1;

endpackage

// File: rtl/cook_sequencer_rise_detect.sv
// Registered rising-edge detector; the reset value of the history flop is a parameter.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= RST_VAL;
        end else if (en_i) begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/cook_sequencer.sv
// Kitchen timer sequencer: SET -> COOK -> DONE countdown with minute/second entry.
// Optional pause on start edge in COOK is built when COOK_SEQUENCER_PAUSE_EN is defined.
module cook_sequencer
    import cook_pkg::*;
#(
    parameter int MAX_MIN = 59,
    parameter int MAX_SEC = 59
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               tick_1hz,
    input  logic               minutes,
    input  logic               seconds,
    input  logic               start,
    output logic [FIELD_W-1:0] q_minutes,
    output logic [FIELD_W-1:0] q_seconds,
    output logic [1:0]         state,
    output logic [1:0]         LED,
    output logic               done_disp
);

    localparam logic [FIELD_W-1:0] MAX_MIN_V = FIELD_W'(MAX_MIN);
    localparam logic [FIELD_W-1:0] MAX_SEC_V = FIELD_W'(MAX_SEC);
    localparam logic [FIELD_W-1:0] ONE       = FIELD_W'(1);

    state_e             state_q, state_d;
    logic [FIELD_W-1:0] min_q, min_d;
    logic [FIELD_W-1:0] sec_q, sec_d;
    logic [FIELD_W-1:0] pmin_q, pmin_d;
    logic [FIELD_W-1:0] psec_q, psec_d;
    logic               start_rise_raw;
    logic               start_rise;
`ifdef COOK_SEQUENCER_PAUSE_EN
    logic               blink_q, blink_d;
`endif

    // History resets high so a start held through reset is not seen as an edge.
    rise_detect #(.RST_VAL(1'b1)) u_start_edge (
        .clk    (clk),
        .rst_n  (reset),
        .en_i   (enable),
        .d_i    (start),
        .rise_o (start_rise_raw)
    );

    assign start_rise = start_rise_raw & enable;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SET;
            min_q   <= '0;
            sec_q   <= '0;
            pmin_q  <= '0;
            psec_q  <= '0;
`ifdef COOK_SEQUENCER_PAUSE_EN
            blink_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            pmin_q  <= pmin_d;
            psec_q  <= psec_d;
`ifdef COOK_SEQUENCER_PAUSE_EN
            blink_q <= blink_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        pmin_d  = pmin_q;
        psec_d  = psec_q;
`ifdef COOK_SEQUENCER_PAUSE_EN
        blink_d = blink_q;
`endif
        if (enable) begin
            case (state_q)
                ST_SET: begin
                    // A start edge wins over any coincident button pulse.
                    if (start_rise) begin
                        if ((min_q != '0) || (sec_q != '0)) begin
                            pmin_d  = min_q;
                            psec_d  = sec_q;
                            state_d = ST_COOK;
                        end
                    end else begin
                        if (minutes) min_d = (min_q >= MAX_MIN_V) ? '0 : min_q + ONE;
                        if (seconds) sec_d = (sec_q >= MAX_SEC_V) ? '0 : sec_q + ONE;
                    end
                end
                ST_COOK: begin
`ifdef COOK_SEQUENCER_PAUSE_EN
                    if (start_rise) begin
                        state_d = ST_PAUSE;
                        blink_d = 1'b1;
                    end else
`endif
                    if (tick_1hz) begin
                        if (sec_q != '0) begin
                            sec_d = sec_q - ONE;
                        end else if (min_q != '0) begin
                            min_d = min_q - ONE;
                            sec_d = MAX_SEC_V;
                        end
                        if ((min_d == '0) && (sec_d == '0)) state_d = ST_DONE;
                    end
                end
`ifdef COOK_SEQUENCER_PAUSE_EN
                ST_PAUSE: begin
                    if (start_rise) begin
                        state_d = ST_COOK;
                    end else if (tick_1hz) begin
                        blink_d = ~blink_q;
                    end
                end
`endif
                ST_DONE: begin
                    if (start_rise) begin
                        min_d   = pmin_q;
                        sec_d   = psec_q;
                        state_d = ST_SET;
                    end
                end
                default: state_d = ST_SET;
            endcase
        end
    end

    always_comb begin
        LED           = 2'b00;
        LED[LED_COOK] = (state_q == ST_COOK);
        LED[LED_DONE] = (state_q == ST_DONE);
`ifdef COOK_SEQUENCER_PAUSE_EN
        if (state_q == ST_PAUSE) LED[LED_COOK] = blink_q;
`endif
    end

    assign q_minutes = min_q;
    assign q_seconds = sec_q;
    assign state     = state_q;
    assign done_disp = (state_q == ST_DONE);

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_cook_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       tick_1hz;
    logic       minutes;
    logic       seconds;
    logic       start;
    logic [5:0] q_minutes;
    logic [5:0] q_seconds;
    logic [1:0] state;
    logic [1:0] LED;
    logic       done_disp;

    int npass = 0;
    int ntot  = 0;

    localparam int SET = 0, COOK = 1, PAUSE = 2, DONE = 3;

    cook_sequencer #(.MAX_MIN(59), .MAX_SEC(59)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .tick_1hz  (tick_1hz),
        .minutes   (minutes),
        .seconds   (seconds),
        .start     (start),
        .q_minutes (q_minutes),
        .q_seconds (q_seconds),
        .state     (state),
        .LED       (LED),
        .done_disp (done_disp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en, tk, mi, se, st;
        int   emin, esec, est, eled, edone;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string nm, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_out(input string nm, input int emin, input int esec,
                           input int est, input int eled, input int edone);
        chk({nm, ".min"},  int'(q_minutes), emin);
        chk({nm, ".sec"},  int'(q_seconds), esec);
        chk({nm, ".state"}, int'(state),    est);
        chk({nm, ".led"},  int'(LED),       eled);
        chk({nm, ".done"}, int'(done_disp), edone);
    endtask

    task automatic cyc(input logic mi, input logic se, input logic tk, input logic st);
        minutes  = mi;
        seconds  = se;
        tick_1hz = tk;
        start    = st;
        @(posedge clk);
        #1;
        minutes  = 1'b0;
        seconds  = 1'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b1; tick_1hz = 1'b0;
        minutes = 1'b0; seconds = 1'b0; start = 1'b0;

        // en, tick, min, sec, start -> min, sec, state, LED, done
        tv[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, SET,  0, 0};
        tv[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, SET,  0, 0};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1, SET,  0, 0};
        tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 2, SET,  0, 0};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 3, SET,  0, 0};
        tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 3, COOK, 1, 0};
        tv[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2, 3, COOK, 1, 0};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2, COOK, 1, 0};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2, COOK, 1, 0};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 2, COOK, 1, 0};
        tv[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1, COOK, 1, 0};
        tv[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1, COOK, 1, 0};

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_out("reset", 0, 0, SET, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            enable = tv[i].en;
            cyc(tv[i].mi, tv[i].se, tv[i].tk, tv[i].st);
            chk_out($sformatf("vec%0d", i), tv[i].emin, tv[i].esec, tv[i].est,
                    tv[i].eled, tv[i].edone);
        end
        enable = 1'b1;

        // Count 02:01 down to DONE; the final tick flips state on the same edge.
        for (int i = 0; i < 120; i++) cyc(0, 0, 1, 0);
        chk_out("cd_0001", 0, 1, COOK, 1, 0);
        cyc(0, 0, 1, 0);
        chk_out("cd_done", 0, 0, DONE, 2, 1);
        cyc(1, 1, 1, 0);
        chk_out("done_hold", 0, 0, DONE, 2, 1);
        cyc(0, 0, 0, 1);
        chk_out("done_restart", 2, 3, SET, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk_out("set_both", 3, 4, SET, 0, 0);

        // 01:00 -> 00:59 -> DONE after 60 ticks total.
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk_out("m1_cook", 1, 0, COOK, 1, 0);
        cyc(0, 0, 1, 0);
        chk_out("m1_tick1", 0, 59, COOK, 1, 0);
        for (int i = 0; i < 58; i++) cyc(0, 0, 1, 0);
        chk_out("m1_0001", 0, 1, COOK, 1, 0);
        cyc(0, 0, 1, 0);
        chk_out("m1_done", 0, 0, DONE, 2, 1);

        // Field wrap, zero-time start ignored, start beats a coincident pulse.
        do_reset();
        for (int i = 0; i < 59; i++) cyc(1, 0, 0, 0);
        chk("wrap_min59", int'(q_minutes), 59);
        cyc(1, 0, 0, 0);
        chk("wrap_min0", int'(q_minutes), 0);
        for (int i = 0; i < 60; i++) cyc(0, 1, 0, 0);
        chk("wrap_sec0", int'(q_seconds), 0);
        cyc(0, 0, 0, 1);
        chk_out("zero_start", 0, 0, SET, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk_out("zero_start_pulse", 0, 0, SET, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 1);
        chk_out("start_beats_pulse", 0, 1, COOK, 1, 0);
        cyc(0, 0, 1, 0);
        chk_out("sec1_done", 0, 0, DONE, 2, 1);

        // Asynchronous reset mid-COOK, start held high across release.
        do_reset();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        chk_out("mid_cook", 1, 30, COOK, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, SET, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk_out("start_held", 0, 0, SET, 0, 0);
        cyc(0, 0, 0, 0);

`ifdef COOK_SEQUENCER_PAUSE_EN
        do_reset();
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        chk_out("pause_enter", 0, 10, PAUSE, 1, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        chk_out("pause_hold", 0, 10, PAUSE, 0, 0);
        cyc(0, 0, 0, 1);
        chk_out("pause_resume", 0, 10, COOK, 1, 0);
        cyc(0, 0, 1, 0);
        chk_out("resume_tick", 0, 9, COOK, 1, 0);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
